// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: default sizes, the ID width
// helper and the FSM state encoding.
//
// Contents:
//   DEF_WIDTH    default operand / sum width
//   DEF_NUM_REQ  default number of requesters sharing the adder
//   id_width()   width of a requester index for a given requester count
//   DEF_ID_W     requester index width for the default requester count
//   state_t      IDLE / EXEC / RESP
package adder_arb_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    // A single requester still needs a 1-bit ID port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker. It returns the first valid requester
// found at or after the pointer. The search moves upward and wraps from
// NUM_REQ-1 back to 0.
//
// Ports:
//   valid      in   NUM_REQ  request flags
//   ptr        in   ID_W     highest-priority index for this pick
//   grant      out  NUM_REQ  one-hot grant (all-zero if nothing is valid)
//   idx        out  ID_W     binary index of the grant
//   any_valid  out  1        at least one request is valid
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_valid
);

    // Walk the offsets from the pointer. The first hit wins, and later hits
    // are masked by any_valid.
    always_comb begin
        int cand;
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + off) % NUM_REQ;
            if (!any_valid && valid[cand]) begin
                any_valid   = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH+1-bit adder.
// Requesters offer operand pairs with a valid/ready handshake. The winner's
// operands are latched in IDLE. They are added in EXEC. The result is held
// in RESP until the consumer takes it.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   req_valid  in   NUM_REQ        per-requester operand-valid flags
//   req_a      in   NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NUM_REQ*WIDTH  operand B, same packing as req_a
//   req_ready  out  NUM_REQ        one-hot grant, only ever high in IDLE
//   rsp_valid  out  1              result valid
//   rsp_ready  in   1              result consumer ready
//   rsp_sum    out  WIDTH          sum modulo 2^WIDTH
//   rsp_carry  out  1              carry-out of the addition
//   rsp_id     out  ID_W           requester that owns the result
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_sum,
    output logic                         rsp_carry,
    output logic [id_width(NUM_REQ)-1:0] rsp_id
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [ID_W-1:0]    id_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [ID_W-1:0]    ptr_next;
    logic [WIDTH:0]     sum_full;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // The grant is combinational, so operands are accepted in the same IDLE
    // cycle that the request is seen. It is masked during reset so that no
    // handshake can appear while the block is being cleared.
    assign req_ready = (state == IDLE && !rst) ? pick_grant : '0;

    // The wrap is explicit so that non-power-of-two NUM_REQ also works.
    assign ptr_next = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    // This is the only adder, and it works on the latched operands.
    assign sum_full = {1'b0, a_q} + {1'b0, b_q};

    // The response fields change only on the EXEC->RESP edge. This keeps
    // them stable for as long as RESP is stalled by backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        a_q    <= a_arr[pick_idx];
                        b_q    <= b_arr[pick_idx];
                        id_q   <= pick_idx;
                        rr_ptr <= ptr_next;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    {rsp_carry, rsp_sum} <= sum_full;
                    rsp_id               <= id_q;
                    rsp_valid            <= 1'b1;
                    state                <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter. Each task covers one scenario and
// compares DUT outputs against hand-computed values. Inputs change 2 time
// units after the rising edge, and outputs are sampled 1 unit later.
module tb_adder_arbiter;

    localparam int NR  = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic [IDW-1:0]    rsp_id;

    int errors = 0;
    int checks = 0;

    adder_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '1;
        req_b     = '1;
        rsp_ready = 1'b1;
        step();
        step();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_sum !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_carry got=%b exp=0", rsp_carry); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_req(0, 32'd5, 32'd7);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL single_exec_ready got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_exec_valid got=%b exp=0", rsp_valid); end
        step();
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_sum !== 32'd12) begin errors++; $display("[TB] FAIL single_rsp_sum got=%0d exp=12", rsp_sum); end
        checks++; if (rsp_carry !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_carry got=%b exp=0", rsp_carry); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL single_rsp_id got=%0d exp=0", rsp_id); end
        step();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_one_cycle got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int k;
        logic [NR-1:0] exp_gnt;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 32'(i * 10), 32'(i));
        req_valid = 4'b1111;
        k = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                if (k < 5) begin
                    exp_gnt = NR'(1) << exp_order[k];
                    checks++; if (req_ready !== exp_gnt) begin errors++; $display("[TB] FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, exp_gnt); end
                    checks++; if (cyc != 3 * k) begin errors++; $display("[TB] FAIL rr_spacing_%0d got=cycle%0d exp=cycle%0d", k, cyc, 3 * k); end
                end
                k++;
            end
            step();
        end
        checks++; if (k != 5) begin errors++; $display("[TB] FAIL rr_grant_count got=%0d exp=5", k); end
        req_valid = '0;
        step();
        step();
        step();
    endtask

    task automatic test_overflow();
        int            ids  [3] = '{1, 2, 3};
        logic [W-1:0]  av   [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0]  bv   [3] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        logic [W-1:0]  sv   [3] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        logic          cv   [3] = '{1'b1, 1'b1, 1'b0};
        logic [NR-1:0] gnt;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            gnt = NR'(1) << ids[t];
            set_req(ids[t], av[t], bv[t]);
            req_valid = gnt;
            #1;
            checks++; if (req_ready !== gnt) begin errors++; $display("[TB] FAIL ovf_grant_%0d got=%b exp=%b", t, req_ready, gnt); end
            step();
            req_valid = '0;
            step();
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid_%0d got=%b exp=1", t, rsp_valid); end
            checks++; if (rsp_sum !== sv[t]) begin errors++; $display("[TB] FAIL ovf_sum_%0d got=%h exp=%h", t, rsp_sum, sv[t]); end
            checks++; if (rsp_carry !== cv[t]) begin errors++; $display("[TB] FAIL ovf_carry_%0d got=%b exp=%b", t, rsp_carry, cv[t]); end
            checks++; if (rsp_id !== IDW'(ids[t])) begin errors++; $display("[TB] FAIL ovf_id_%0d got=%0d exp=%0d", t, rsp_id, ids[t]); end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 32'd100, 32'd23);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL bp_first_grant got=%b exp=0001", req_ready); end
        step();
        set_req(2, 32'd40, 32'd2);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_exec_ready got=%b exp=0000", req_ready); end
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid_%0d got=%b exp=1", i, rsp_valid); end
            checks++; if (rsp_sum !== 32'd123) begin errors++; $display("[TB] FAIL bp_hold_sum_%0d got=%0d exp=123", i, rsp_sum); end
            checks++; if (rsp_carry !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_carry_%0d got=%b exp=0", i, rsp_carry); end
            checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL bp_hold_id_%0d got=%0d exp=0", i, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold_ready_%0d got=%b exp=0000", i, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_valid got=%b exp=1", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL bp_release_ready got=%b exp=0000", req_ready); end
        step();
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_req2_grant got=%b exp=0100", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle_valid got=%b exp=0", rsp_valid); end
        step();
        req_valid = '0;
        step();
        #1;
        checks++; if (rsp_sum !== 32'd42) begin errors++; $display("[TB] FAIL bp_req2_sum got=%0d exp=42", rsp_sum); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL bp_req2_id got=%0d exp=2", rsp_id); end
        step();
    endtask

    task automatic test_reset_exec();
        do_reset();
        set_req(1, 32'd9, 32'd9);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rexec_first_grant got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rexec_no_rsp_%0d got=%b exp=0", i, rsp_valid); end
            step();
        end
        set_req(1, 32'd1, 32'd2);
        set_req(3, 32'd30, 32'd4);
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rexec_ptr0_grant got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b1000;
        step();
        #1;
        checks++; if (rsp_sum !== 32'd3) begin errors++; $display("[TB] FAIL rexec_sum got=%0d exp=3", rsp_sum); end
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("[TB] FAIL rexec_id got=%0d exp=1", rsp_id); end
        req_valid = '0;
        step();
        step();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(2, 32'd2, 32'd2);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_grant2 got=%b exp=0100", req_ready); end
        step();
        set_req(0, 32'd11, 32'd0);
        set_req(3, 32'd7, 32'd8);
        req_valid = 4'b1001;
        step();
        step();
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_grant3 got=%b exp=1000", req_ready); end
        step();
        req_valid = 4'b0101;
        step();
        #1;
        checks++; if (rsp_id !== 2'd3) begin errors++; $display("[TB] FAIL wrap_id3 got=%0d exp=3", rsp_id); end
        checks++; if (rsp_sum !== 32'd15) begin errors++; $display("[TB] FAIL wrap_sum3 got=%0d exp=15", rsp_sum); end
        step();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_grant0 got=%b exp=0001", req_ready); end
        req_valid = '0;
        step();
        step();
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_reset_exec();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
